ltile_clb_frac_lutk_logic: RTL and testbench
============================================

LTILE_CLB_FRAC_LUTK_LOGIC -- requirements
Module: ltile_clb_frac_lutk_logic

Interface
REQ-001 SHALL have parameter K, default 4, LUT input count, legal range 3..6.
REQ-002 SHALL have localparam CFG_LEN = 2^K + 1, or 2^K + 3 with FRAC_LOGIC_FF_EN.
REQ-003 SHALL have port prog_clk  input  1  the single clock.
REQ-004 SHALL have port prog_reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port ccff_en  input  1  config shift enable.
REQ-006 SHALL have port ccff_head  input  1  config chain serial in.
REQ-007 SHALL have port frac_logic_in  input  K  LUT inputs; bit i has index weight 2^i.
REQ-008 SHALL have port frac_logic_out  output  2  logic outputs.
REQ-009 SHALL have port ccff_tail  output  1  config chain serial out.
REQ-010 SHALL have port cfg_done  output  1  chain fully loaded.

Function
REQ-011 SHALL hold cfg[0:CFG_LEN-1]; on ccff_en=1, shift cfg[0]<=ccff_head and cfg[i]<=cfg[i-1]; on ccff_en=0, hold.
REQ-012 SHALL drive ccff_tail = cfg[CFG_LEN-1], direct from the register, with no added stage.
REQ-013 SHALL map fields as follows: cfg[0..2^K-1] = LUT truth table; cfg[2^K] = mode; cfg[2^K+1..2^K+2] = ff_byp[0..1] (FF build only).
REQ-014 SHALL use a bit counter that increments once per shift and saturates at CFG_LEN.
REQ-015 SHALL register cfg_done high on the clock edge where the count reaches CFG_LEN; it then stays high through further shifts until reset.
REQ-016 SHALL compute lut_k = cfg[idx(frac_logic_in[0:K-1])].
REQ-017 SHALL compute lut_a = cfg[idx(frac_logic_in[0:K-2])] (lower half) and lut_b = cfg[2^(K-1) + idx(frac_logic_in[0:K-2])] (upper half).
REQ-018 SHALL compute comb0 = mode ? lut_a : lut_k, and comb1 = lut_b.
REQ-019 SHALL force frac_logic_out to 0 while cfg_done=0 or ccff_en=1.
REQ-020 SHALL give a combinational path from input to output, with 0-cycle latency, when unregistered.
REQ-021 SHALL, on simultaneous prog_reset and ccff_en, give reset priority: no shift, counter stays 0.

Reset
REQ-022 SHALL, on prog_reset=1 at a prog_clk edge, clear cfg, counter, cfg_done and output FFs to 0.
REQ-023 SHALL hold ccff_tail=0 and frac_logic_out=0 from the edge after reset is sampled.
REQ-024 SHALL abort any partial load on reset mid-shift; a full CFG_LEN-bit reload is then required.

Configuration
REQ-025 SHALL, with FRAC_LOGIC_FF_EN defined, add two output FFs, each capturing combj on each edge where cfg_done=1 and ccff_en=0.
REQ-026 SHALL, with FRAC_LOGIC_FF_EN defined, drive out j from the FF when ff_byp[j]=0 (1-cycle latency) and from combj when ff_byp[j]=1.
REQ-027 SHALL, without FRAC_LOGIC_FF_EN, contain no FFs and no ff_byp bits; outputs are combj, gated per REQ-019.

Structure
REQ-028 SHALL place cfg_len(K, ff_en), the field offset constants (LUT_OFS, MODE_OFS, FFBYP_OFS) and the legal-K bounds in shared package ltile_clb_frac_pkg.
REQ-029 SHALL implement the shift register, counter and cfg_done in one sub-module, ltile_clb_frac_cfg_chain; LUT evaluation and output FFs sit at top level.

Verification
REQ-030 SHALL, with K=4, no FF: shift 17 bits (mode=0 first, then LUT bits 15..0 = 16'h8000) -> cfg_done=1 on the 17th edge; in=4'hF gives out0=1; in=4'h7 gives out0=0; out1 = upper-half lookup.
REQ-031 SHALL, with K=4, no FF: mode=1, lower=8'h80, upper=8'hFE -> in=4'b0111 gives out=2'b11; in=4'b0000 gives 2'b00; in=4'b1001 gives out0=0, out1=1 (in[3] ignored).
REQ-032 SHALL, on reset after 10 of 17 shifts -> cfg_done=0, ccff_tail=0, outputs 0; a 17-bit reload then restores function.
REQ-033 SHALL, for pass-through: shift 1 then zeros -> ccff_tail rises after exactly CFG_LEN shifts; with ccff_en=0 across gaps, cfg is unchanged and cfg_done stays 1.
REQ-034 SHALL, with FRAC_LOGIC_FF_EN, ff_byp=2'b00 -> out0 lags an input step by one prog_clk; ff_byp=2'b11 -> same-cycle response; raising ccff_en forces outputs to 0 immediately.

Source files
------------

// File: rtl/ltile_clb_frac_pkg.sv
// Shared constants for the fractured K-input LUT tile: legal K range,
// configuration-image field offsets and the chain-length helper.
package ltile_clb_frac_pkg;

   localparam int K_MIN = 3;
   localparam int K_MAX = 6;

   // LUT_OFS is absolute; MODE_OFS and FFBYP_OFS count from the end of the 2^K truth table.
   localparam int LUT_OFS   = 0;
   localparam int MODE_OFS  = 0;
   localparam int FFBYP_OFS = 1;

   function automatic int cfg_len(input int k, input bit ff_en);
      return (1 << k) + (ff_en ? 3 : 1);
   endfunction

endpackage

// File: rtl/ltile_clb_frac_cfg_chain.sv
// Serial configuration chain: shift register, saturating bit counter and the
// sticky cfg_done flag that marks a fully loaded image.
module ltile_clb_frac_cfg_chain #(
   parameter int CFG_LEN = 17
) (
   input  logic               prog_clk,
   input  logic               prog_reset,
   input  logic               ccff_en,
   input  logic               ccff_head,
   output logic [CFG_LEN-1:0] cfg,
   output logic               ccff_tail,
   output logic               cfg_done
);

   localparam int                CNT_W   = $clog2(CFG_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_LEN);

   logic [CNT_W-1:0] bit_cnt;

   // NOTE: non-blocking assignments let every stage take its neighbour's pre-edge value.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         cfg      <= '0;
         bit_cnt  <= '0;
         cfg_done <= 1'b0;
      end else if (ccff_en) begin
         cfg <= {cfg[CFG_LEN-2:0], ccff_head};
         if (bit_cnt != CNT_MAX)
            bit_cnt <= bit_cnt + 1'b1;
         if (bit_cnt == CNT_MAX - 1'b1)
            cfg_done <= 1'b1;
      end
   end

   assign ccff_tail = cfg[CFG_LEN-1];

endmodule

// File: rtl/ltile_clb_frac_lutk_logic.sv
// Fracturable K-input LUT: one K-LUT or two (K-1)-LUTs sharing inputs, loaded
// over a serial chain. Define FRAC_LOGIC_FF_EN to add bypassable output FFs.
module ltile_clb_frac_lutk_logic
   import ltile_clb_frac_pkg::*;
#(
   parameter int K = 4
) (
   input  logic         prog_clk,
   input  logic         prog_reset,
   input  logic         ccff_en,
   input  logic         ccff_head,
   input  logic [K-1:0] frac_logic_in,
   output logic [1:0]   frac_logic_out,
   output logic         ccff_tail,
   output logic         cfg_done
);

`ifdef FRAC_LOGIC_FF_EN
   localparam bit FF_EN = 1'b1;
`else
   localparam bit FF_EN = 1'b0;
`endif
   localparam int LUT_SIZE = 1 << K;
   localparam int HALF     = LUT_SIZE / 2;
   localparam int CFG_LEN  = cfg_len(K, FF_EN);

   logic [CFG_LEN-1:0]  cfg;
   logic [LUT_SIZE-1:0] tt;
   logic [HALF-1:0]     tt_lo;
   logic [HALF-1:0]     tt_hi;
   logic [K-2:0]        half_idx;
   logic                mode;
   logic                lut_k;
   logic                lut_a;
   logic                lut_b;
   logic [1:0]          comb;
   logic                out_en;

   ltile_clb_frac_cfg_chain #(
      .CFG_LEN (CFG_LEN)
   ) u_cfg_chain (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .ccff_en    (ccff_en),
      .ccff_head  (ccff_head),
      .cfg        (cfg),
      .ccff_tail  (ccff_tail),
      .cfg_done   (cfg_done)
   );

   assign tt       = cfg[LUT_OFS +: LUT_SIZE];
   assign mode     = cfg[LUT_SIZE + MODE_OFS];
   assign tt_lo    = tt[HALF-1:0];
   assign tt_hi    = tt[LUT_SIZE-1:HALF];
   assign half_idx = frac_logic_in[K-2:0];

   // In fractured mode the top input is ignored and each half is its own (K-1)-LUT.
   assign lut_k = tt[frac_logic_in];
   assign lut_a = tt_lo[half_idx];
   assign lut_b = tt_hi[half_idx];
   assign comb  = {lut_b, mode ? lut_a : lut_k};

   // Outputs stay quiet until an image is complete and while it is being rewritten.
   assign out_en = cfg_done & ~ccff_en;

`ifdef FRAC_LOGIC_FF_EN
   logic [1:0] ff_q;
   logic [1:0] ff_byp;

   assign ff_byp = cfg[LUT_SIZE + FFBYP_OFS +: 2];

   always_ff @(posedge prog_clk) begin
      if (prog_reset)
         ff_q <= 2'b00;
      else if (out_en)
         ff_q <= comb;
   end

   assign frac_logic_out = out_en ? ((ff_byp & comb) | (~ff_byp & ff_q)) : 2'b00;
`else
   assign frac_logic_out = out_en ? comb : 2'b00;
`endif

endmodule

// File: tb/tb_ltile_clb_frac_lutk_logic.sv
// Directed bench for ltile_clb_frac_lutk_logic (K=4): scoreboard queue of
// expected values, immediate-assertion checks, one summary line.
module tb_ltile_clb_frac_lutk_logic;

   localparam int K        = 4;
   localparam int LUT_SIZE = 16;
`ifdef FRAC_LOGIC_FF_EN
   localparam int CFG_LEN  = LUT_SIZE + 3;
`else
   localparam int CFG_LEN  = LUT_SIZE + 1;
`endif

   logic         prog_clk;
   logic         prog_reset;
   logic         ccff_en;
   logic         ccff_head;
   logic [K-1:0] frac_logic_in;
   logic [1:0]   frac_logic_out;
   logic         ccff_tail;
   logic         cfg_done;

   ltile_clb_frac_lutk_logic #(.K(K)) dut (
      .prog_clk       (prog_clk),
      .prog_reset     (prog_reset),
      .ccff_en        (ccff_en),
      .ccff_head      (ccff_head),
      .frac_logic_in  (frac_logic_in),
      .frac_logic_out (frac_logic_out),
      .ccff_tail      (ccff_tail),
      .cfg_done       (cfg_done)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   typedef struct {
      string      tag;
      logic [1:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic expect_val(input string tag, input logic [1:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [1:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0b required=none", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%0b required=%0b", e.tag, obs, e.exp);
         end
      end
   endtask

   function automatic logic [1:0] model(input logic [15:0] tt, input logic mode,
                                        input logic [3:0] in);
      logic k_out, a_out, b_out;
      k_out = tt[in];
      a_out = tt[{1'b0, in[2:0]}];
      b_out = tt[{1'b1, in[2:0]}];
      return {b_out, mode ? a_out : k_out};
   endfunction

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic shift_bit(input logic b);
      ccff_en   = 1'b1;
      ccff_head = b;
      tick();
   endtask

   task automatic idle(input int n);
      ccff_en = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      prog_reset = 1'b1;
      tick();
      prog_reset = 1'b0;
   endtask

   // Builds the image with cfg[i] at img[i]; the highest index is shifted first.
   task automatic load(input logic [1:0] byp, input logic mode, input logic [15:0] tt,
                       input bit rst_first);
      logic [CFG_LEN-1:0] img;
      img = '0;
      img[LUT_SIZE-1:0] = tt;
      img[LUT_SIZE]     = mode;
`ifdef FRAC_LOGIC_FF_EN
      img[LUT_SIZE+2:LUT_SIZE+1] = byp;
`endif
      if (rst_first) do_reset();
      for (int i = CFG_LEN - 1; i >= 0; i--) begin
         if (i == CFG_LEN / 2) begin
            expect_val("out_gated_during_load", 2'b00);
            check(frac_logic_out);
         end
         if (i == 0) begin
            expect_val("done_before_last_shift", 2'b00);
            check({1'b0, cfg_done});
         end
         shift_bit(img[i]);
      end
      expect_val("done_after_last_shift", 2'b01);
      check({1'b0, cfg_done});
      ccff_en = 1'b0;
   endtask

   task automatic eval(input string tag, input logic [3:0] in, input logic [1:0] exp);
      frac_logic_in = in;
      expect_val(tag, exp);
      #1;
      check(frac_logic_out);
   endtask

   initial begin
      logic [15:0] tt;
      logic        mode;
      logic [3:0]  in;

      prog_reset    = 1'b1;
      ccff_en       = 1'b1;
      ccff_head     = 1'b1;
      frac_logic_in = 4'hF;
      tick();
      tick();
      expect_val("reset_done", 2'b00);   check({1'b0, cfg_done});
      expect_val("reset_tail", 2'b00);   check({1'b0, ccff_tail});
      expect_val("reset_out",  2'b00);   check(frac_logic_out);
      prog_reset = 1'b0;
      ccff_en    = 1'b0;

      // Unfractured 4-LUT: AND of all inputs, upper half decides out1.
      load(2'b11, 1'b0, 16'h8000, 1'b1);
      eval("and4_in_f", 4'hF, 2'b11);
      eval("and4_in_7", 4'h7, 2'b10);
      eval("and4_in_3", 4'h3, model(16'h8000, 1'b0, 4'h3));

      // Fractured mode: two independent 3-LUTs, in[3] ignored.
      load(2'b11, 1'b1, {8'hFE, 8'h80}, 1'b1);
      eval("frac_in_0111", 4'b0111, 2'b11);
      eval("frac_in_0000", 4'b0000, 2'b00);
      eval("frac_in_1001", 4'b1001, 2'b10);
      eval("frac_in_1111", 4'b1111, 2'b11);

      frac_logic_in = 4'b0111;
      ccff_en = 1'b1;
      expect_val("en_forces_zero", 2'b00);
      #1 check(frac_logic_out);
      ccff_en = 1'b0;
      expect_val("en_release", 2'b11);
      #1 check(frac_logic_out);

      // Reset in the middle of a load, with ccff_en held high through the reset edge.
      do_reset();
      repeat (10) shift_bit(1'b1);
      prog_reset = 1'b1;
      tick();
      expect_val("abort_done", 2'b00);   check({1'b0, cfg_done});
      expect_val("abort_tail", 2'b00);   check({1'b0, ccff_tail});
      expect_val("abort_out",  2'b00);   check(frac_logic_out);
      prog_reset = 1'b0;
      load(2'b11, 1'b1, {8'hFE, 8'h80}, 1'b0);
      eval("reload_in_0111", 4'b0111, 2'b11);
      eval("reload_in_1001", 4'b1001, 2'b10);

      // Pass-through: a single 1 reaches the tail after exactly CFG_LEN shifts.
      do_reset();
      shift_bit(1'b1);
      for (int i = 1; i < CFG_LEN - 1; i++) begin
         shift_bit(1'b0);
         if (i == 5) begin
            idle(3);
            expect_val("gap_tail_low", 2'b00);
            check({1'b0, ccff_tail});
         end
      end
      expect_val("tail_before_len", 2'b00);  check({1'b0, ccff_tail});
      shift_bit(1'b0);
      expect_val("tail_at_len", 2'b01);      check({1'b0, ccff_tail});
      idle(3);
      expect_val("tail_held_idle", 2'b01);   check({1'b0, ccff_tail});
      expect_val("done_held_idle", 2'b01);   check({1'b0, cfg_done});
      shift_bit(1'b0);
      ccff_en = 1'b0;
      expect_val("tail_after_extra", 2'b00); check({1'b0, ccff_tail});
      expect_val("done_sticky", 2'b01);      check({1'b0, cfg_done});

      // Random images checked against the reference model.
      for (int r = 0; r < 3; r++) begin
         tt   = 16'($urandom);
         mode = 1'($urandom);
         load(2'b11, mode, tt, 1'b1);
         for (int j = 0; j < 4; j++) begin
            in = 4'($urandom);
            eval("random_lookup", in, model(tt, mode, in));
         end
      end

`ifdef FRAC_LOGIC_FF_EN
      // Registered outputs lag one edge; bypassed outputs follow immediately.
      load(2'b00, 1'b0, 16'h8000, 1'b1);
      frac_logic_in = 4'h0;
      tick();
      expect_val("ff_initial", 2'b00);     check(frac_logic_out);
      frac_logic_in = 4'hF;
      expect_val("ff_lag_before", 2'b00);
      #1 check(frac_logic_out);
      tick();
      expect_val("ff_lag_after", 2'b11);   check(frac_logic_out);
      ccff_en = 1'b1;
      expect_val("ff_en_forces_zero", 2'b00);
      #1 check(frac_logic_out);
      ccff_en = 1'b0;
      load(2'b11, 1'b0, 16'h8000, 1'b1);
      frac_logic_in = 4'h0;
      tick();
      eval("byp_same_cycle", 4'hF, 2'b11);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
